chacha_seq: RTL
===============

CHACHA_SEQ -- requirements
Module: chacha_seq

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 20, giving the double-half rounds per block; legal values are even, 2..30.
REQ-002 The block SHALL have parameter CTR_BYTES, default 8, giving counter length: 8 selects 64-bit counter with 64-bit nonce; 4 selects 32-bit counter with 96-bit nonce.
REQ-003 The block SHALL have ports, in order: clk in 1 clock; rst_n in 1 reset, asynchronous and active-low; wr_key in 1 start 32-byte key write; wr_nnc in 1 start nonce write; wr_ctr in 1 start counter write; hold in 1 pause computation; rd_blk in 1 start 64-byte block read; blk_ready out 1 block available; busy out 1 computing; write out 1 datapath write strobe; addr out 6 datapath byte address; out_en out 1 datapath output enable; clear out 1 load initial state; calc out 1 quarter-round step strobe; step out 2 quarter-round step index; shift out 1 rotate strobe; shift_dir out 1 rotate direction; shift_ctr out 5 rotate bit index; add_back out 1 add initial state; inc_ctr out 1 increment counter.

Function
REQ-004 The block SHALL implement states CLEAR, ROUND, SHIFT, ADD, READY, READING, INCREMENT, WRITE_KEY, WRITE_NNC, WRITE_CTR, one-hot encoded.
REQ-005 Write priority SHALL be wr_key > wr_nnc > wr_ctr > rd_blk, evaluated in every state, including mid-computation (which aborts the computation).
REQ-006 Write lengths/bases SHALL be: key 32 bytes at 0x10; counter CTR_BYTES bytes at 0x30; nonce (16-CTR_BYTES) bytes at 0x30+CTR_BYTES.
REQ-007 During a write, write SHALL be 1 and addr = base + byte index, combinationally from the request cycle onward; index increments every cycle.
REQ-008 After the last write byte the state SHALL go to CLEAR and the byte index SHALL reset to 0.
REQ-009 CLEAR SHALL assert clear for one cycle, ignore hold, zero round and step, and go to ROUND.
REQ-010 ROUND with hold=0 SHALL assert calc with step 0,1,2,3 on four consecutive cycles, then increment the round count and go to SHIFT with shift_ctr=0.
REQ-011 SHIFT with hold=0 SHALL assert shift for 32 cycles with shift_ctr 0..31 and shift_dir = round count bit 0; after shift_ctr 31 go to ADD if round count == ROUNDS, else ROUND.
REQ-012 ADD with hold=0 SHALL assert add_back one cycle and go to READY.
REQ-013 hold=1 SHALL freeze the state, step, shift_ctr and round count in ROUND, SHIFT, ADD and INCREMENT, and deassert calc, shift, add_back and inc_ctr.
REQ-014 busy SHALL be 1 in CLEAR, ROUND, SHIFT, ADD and INCREMENT.
REQ-015 blk_ready SHALL be 1 only in READY.
REQ-016 rd_blk SHALL be honoured only in READY or READING; elsewhere it is ignored.
REQ-017 A read SHALL take 64 cycles, addr 0..63, out_en=1 combinationally from the rd_blk cycle; after addr 63 the byte index resets to 0.
REQ-018 Latency SHALL be 2 + 36*ROUNDS cycles from the clear cycle (cycle 0) to the first cycle of blk_ready=1.
REQ-019 Control strobes calc, shift, add_back, inc_ctr, clear and write SHALL be mutually exclusive in every cycle.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state CLEAR and zero the byte index, round, step and shift_ctr.
REQ-021 During reset all outputs SHALL be 0, except busy=1 (state CLEAR).
REQ-022 Reset mid-read or mid-write SHALL discard the transfer; no further addr sequencing follows.

Configuration
REQ-023 With CHACHA_AUTOINC_EN defined, the end of a read SHALL go to INCREMENT, assert inc_ctr one cycle (subject to hold), then go to CLEAR.
REQ-024 Without CHACHA_AUTOINC_EN, the end of a read SHALL go directly to CLEAR; inc_ctr SHALL be tied 0 and INCREMENT is unreachable.

Verification
REQ-025 Release reset, ROUNDS=20, no requests -> clear at cycle 0, blk_ready first high at cycle 722, exactly 80 calc and 640 shift pulses.
REQ-026 ROUNDS=8, hold=1 for 10 cycles during round 3 -> blk_ready at cycle 300, strobe counts 32 calc and 256 shift.
REQ-027 CTR_BYTES=4, wr_nnc pulse -> addr 0x34..0x3F with write=1 for 12 cycles, then clear.
REQ-028 wr_key asserted mid-SHIFT -> write=1 at once, addr 0x10..0x2F, then clear and a full recomputation.
REQ-029 In READY, rd_blk pulse -> addr 0..63 with out_en=1; then with CHACHA_AUTOINC_EN one inc_ctr then clear, without it clear next.
REQ-030 rd_blk and wr_ctr in the same READY cycle -> counter write wins, addr 0x30, out_en=0.

Source files
------------

// File: rtl/chacha_seq_if.sv
// Request/status bundle between a ChaCha sequencer and its host/datapath.
interface chacha_seq_if;
  logic       wr_key;
  logic       wr_nnc;
  logic       wr_ctr;
  logic       hold;
  logic       rd_blk;
  logic       blk_ready;
  logic       busy;
  logic       write;
  logic [5:0] addr;
  logic       out_en;
  logic       clear;
  logic       calc;
  logic [1:0] step;
  logic       shift;
  logic       shift_dir;
  logic [4:0] shift_ctr;
  logic       add_back;
  logic       inc_ctr;

  modport master (
    output wr_key, wr_nnc, wr_ctr, hold, rd_blk,
    input  blk_ready, busy, write, addr, out_en, clear, calc, step,
           shift, shift_dir, shift_ctr, add_back, inc_ctr
  );

  modport slave (
    input  wr_key, wr_nnc, wr_ctr, hold, rd_blk,
    output blk_ready, busy, write, addr, out_en, clear, calc, step,
           shift, shift_dir, shift_ctr, add_back, inc_ctr
  );
endinterface

// File: rtl/chacha_seq.sv
// ChaCha block sequencer: drives a bit-serial quarter-round datapath through key/nonce/counter
// loads, ROUNDS rounds, add-back and a 64-byte read. Optional macro CHACHA_AUTOINC_EN adds a counter bump after reads.
module chacha_seq #(
  parameter int ROUNDS    = 20,
  parameter int CTR_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  chacha_seq_if.slave bus
);

  typedef enum logic [9:0] {
    ST_CLEAR     = 10'b00_0000_0001,
    ST_ROUND     = 10'b00_0000_0010,
    ST_SHIFT     = 10'b00_0000_0100,
    ST_ADD       = 10'b00_0000_1000,
    ST_READY     = 10'b00_0001_0000,
    ST_READING   = 10'b00_0010_0000,
    ST_INCREMENT = 10'b00_0100_0000,
    ST_WRITE_KEY = 10'b00_1000_0000,
    ST_WRITE_NNC = 10'b01_0000_0000,
    ST_WRITE_CTR = 10'b10_0000_0000
  } state_t;

  localparam logic [5:0] KEY_BASE = 6'h10;
  localparam logic [5:0] KEY_LAST = 6'd31;
  localparam logic [5:0] CTR_BASE = 6'h30;
  localparam logic [5:0] CTR_LAST = 6'(CTR_BYTES - 1);
  localparam logic [5:0] NNC_BASE = 6'(48 + CTR_BYTES);
  localparam logic [5:0] NNC_LAST = 6'(15 - CTR_BYTES);
  localparam logic [4:0] RND_LAST = 5'(ROUNDS);

  state_t     r_state, w_state_nxt, w_wr_state;
  logic [5:0] r_idx, w_idx_nxt;
  logic [4:0] r_round, w_round_nxt;
  logic [1:0] r_step, w_step_nxt;
  logic [4:0] r_shift_ctr, w_shift_nxt;
  logic       w_wr_go;
  logic [5:0] w_wr_base, w_cur_base, w_cur_last, w_addr;
  logic       w_write, w_out_en, w_clear, w_calc, w_shift, w_add, w_inc;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_CLEAR;
      r_idx       <= 6'd0;
      r_round     <= 5'd0;
      r_step      <= 2'd0;
      r_shift_ctr <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_round     <= w_round_nxt;
      r_step      <= w_step_nxt;
      r_shift_ctr <= w_shift_nxt;
    end
  end

  // Next-state and strobe decode; a new write request pre-empts whatever the state is doing
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_round_nxt = r_round;
    w_step_nxt  = r_step;
    w_shift_nxt = r_shift_ctr;
    w_wr_go     = 1'b0;
    w_wr_base   = KEY_BASE;
    w_wr_state  = ST_WRITE_KEY;
    w_cur_base  = KEY_BASE;
    w_cur_last  = KEY_LAST;
    w_addr      = 6'd0;
    w_write     = 1'b0;
    w_out_en    = 1'b0;
    w_clear     = 1'b0;
    w_calc      = 1'b0;
    w_shift     = 1'b0;
    w_add       = 1'b0;
    w_inc       = 1'b0;

    if (bus.wr_key) begin
      w_wr_go = (r_state != ST_WRITE_KEY);
    end else if (bus.wr_nnc) begin
      w_wr_go    = (r_state != ST_WRITE_NNC);
      w_wr_base  = NNC_BASE;
      w_wr_state = ST_WRITE_NNC;
    end else if (bus.wr_ctr) begin
      w_wr_go    = (r_state != ST_WRITE_CTR);
      w_wr_base  = CTR_BASE;
      w_wr_state = ST_WRITE_CTR;
    end else begin
      w_wr_go = 1'b0;
    end

    if (r_state == ST_WRITE_NNC) begin
      w_cur_base = NNC_BASE;
      w_cur_last = NNC_LAST;
    end else if (r_state == ST_WRITE_CTR) begin
      w_cur_base = CTR_BASE;
      w_cur_last = CTR_LAST;
    end else begin
      w_cur_base = KEY_BASE;
      w_cur_last = KEY_LAST;
    end

    if (!rst_n) begin
      w_state_nxt = ST_CLEAR;
    end else if (w_wr_go) begin
      w_write     = 1'b1;
      w_addr      = w_wr_base;
      w_idx_nxt   = 6'd1;
      w_state_nxt = w_wr_state;
    end else begin
      case (r_state)
        ST_WRITE_KEY, ST_WRITE_NNC, ST_WRITE_CTR: begin
          w_write = 1'b1;
          w_addr  = w_cur_base + r_idx;
          if (r_idx == w_cur_last) begin
            w_idx_nxt   = 6'd0;
            w_state_nxt = ST_CLEAR;
          end else begin
            w_idx_nxt = r_idx + 6'd1;
          end
        end
        ST_CLEAR: begin
          w_clear     = 1'b1;
          w_round_nxt = 5'd0;
          w_step_nxt  = 2'd0;
          w_shift_nxt = 5'd0;
          w_state_nxt = ST_ROUND;
        end
        ST_ROUND: begin
          if (!bus.hold) begin
            w_calc = 1'b1;
            if (r_step == 2'd3) begin
              w_step_nxt  = 2'd0;
              w_round_nxt = r_round + 5'd1;
              w_shift_nxt = 5'd0;
              w_state_nxt = ST_SHIFT;
            end else begin
              w_step_nxt = r_step + 2'd1;
            end
          end else begin
            w_calc = 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!bus.hold) begin
            w_shift = 1'b1;
            if (r_shift_ctr == 5'd31) begin
              w_shift_nxt = 5'd0;
              w_state_nxt = (r_round == RND_LAST) ? ST_ADD : ST_ROUND;
            end else begin
              w_shift_nxt = r_shift_ctr + 5'd1;
            end
          end else begin
            w_shift = 1'b0;
          end
        end
        ST_ADD: begin
          if (!bus.hold) begin
            w_add       = 1'b1;
            w_state_nxt = ST_READY;
          end else begin
            w_add = 1'b0;
          end
        end
        ST_READY: begin
          if (bus.rd_blk) begin
            w_out_en    = 1'b1;
            w_addr      = 6'd0;
            w_idx_nxt   = 6'd1;
            w_state_nxt = ST_READING;
          end else begin
            w_out_en = 1'b0;
          end
        end
        ST_READING: begin
          w_out_en = 1'b1;
          w_addr   = r_idx;
          if (r_idx == 6'd63) begin
            w_idx_nxt = 6'd0;
`ifdef CHACHA_AUTOINC_EN
            w_state_nxt = ST_INCREMENT;
`else
            w_state_nxt = ST_CLEAR;
`endif
          end else begin
            w_idx_nxt = r_idx + 6'd1;
          end
        end
        ST_INCREMENT: begin
`ifdef CHACHA_AUTOINC_EN
          if (!bus.hold) begin
            w_inc       = 1'b1;
            w_state_nxt = ST_CLEAR;
          end else begin
            w_inc = 1'b0;
          end
`else
          w_state_nxt = ST_CLEAR;
`endif
        end
        default: begin
          w_idx_nxt   = 6'd0;
          w_state_nxt = ST_CLEAR;
        end
      endcase
    end
  end

  assign bus.write     = w_write;
  assign bus.addr      = w_addr;
  assign bus.out_en    = w_out_en;
  assign bus.clear     = w_clear;
  assign bus.calc      = w_calc;
  assign bus.shift     = w_shift;
  assign bus.add_back  = w_add;
  assign bus.inc_ctr   = w_inc;
  assign bus.step      = r_step;
  assign bus.shift_ctr = r_shift_ctr;
  assign bus.shift_dir = (r_state == ST_SHIFT) & r_round[0];
  assign bus.blk_ready = (r_state == ST_READY);
  assign bus.busy      = (r_state == ST_CLEAR) | (r_state == ST_ROUND) | (r_state == ST_SHIFT) |
                         (r_state == ST_ADD)   | (r_state == ST_INCREMENT);

endmodule
